// File: rtl/console_uart_tx_if.sv
// picorv32 native memory bus as seen by a single peripheral slot.
interface console_uart_tx_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/console_uart_tx.sv
// Console transmitter: bus-written bytes are queued in a FIFO and sent as 8N1,
// with a status register and a level TX-empty interrupt.
module console_uart_tx #(
  parameter logic [31:0] ADDR_DATA  = 32'h1000_0000,
  parameter logic [31:0] ADDR_STAT  = 32'h1000_0004,
  parameter int unsigned CLKDIV     = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  console_uart_tx_if.slave bus,
  output logic             irq_txe,
  output logic             uart_tx
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DW = $clog2(CLKDIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  state_e state_q, state_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          irq_en_q, irq_en_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic          tx_q, tx_d;

  logic hit_data, hit_stat, is_wr, full, empty, push, pop, busy, div_last;
  logic unused_ok;

  assign full     = count_q == CW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign busy     = state_q != S_IDLE;
  assign div_last = div_q == DW'(CLKDIV - 1);
  assign is_wr    = |bus.mem_wstrb;
  assign hit_data = bus.mem_valid && !ready_q && (bus.mem_addr == ADDR_DATA);
  assign hit_stat = bus.mem_valid && !ready_q && (bus.mem_addr == ADDR_STAT);
  // A write to a full FIFO is simply not acknowledged; the master keeps it pending.
  assign push     = hit_data && bus.mem_wstrb[0] && !full;
  assign unused_ok = ^bus.mem_wdata[31:8];

  always_comb begin
    ready_d  = 1'b0;
    rdata_d  = '0;
    irq_en_d = irq_en_q;
    if (hit_stat) begin
      ready_d = 1'b1;
      if (!is_wr)
        rdata_d = {16'h0, 8'(count_q), 4'h0, irq_en_q, busy, full, empty};
      else if (bus.mem_wstrb[0])
        irq_en_d = bus.mem_wdata[3];
    end else if (hit_data) begin
      ready_d = !(bus.mem_wstrb[0] && full);
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_START;
      S_START: if (div_last) state_d = S_DATA;
      S_DATA:  if (div_last && bitcnt_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (div_last) state_d = empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the current state, so it trails the FSM by one edge.
  always_comb begin
    pop      = 1'b0;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    div_d    = (busy && !div_last) ? div_q + 1'b1 : '0;
    tx_d     = 1'b1;
    case (state_q)
      S_IDLE:  pop = !empty;
      S_START: tx_d = 1'b0;
      S_DATA: begin
        tx_d = shift_q[0];
        if (div_last) begin
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_STOP:  pop = div_last && !empty;
      default: pop = 1'b0;
    endcase
    if (pop) shift_d = fifo_mem[rptr_q];
    irq_d = irq_en_q && empty && !busy;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      div_q    <= '0;
      irq_en_q <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign irq_txe       = irq_q;
  assign uart_tx       = tx_q;
endmodule

// File: tb/tb_console_uart_tx.sv
// Directed + randomized bench for console_uart_tx; a line monitor decodes 8N1
// frames and the checks compare them against a byte-queue model.
module tb_console_uart_tx;
  localparam int          CLKDIV = 4;
  localparam int          DEPTH  = 16;
  localparam int          FRAME  = 10 * CLKDIV;
  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic irq_txe, uart_tx;
  console_uart_tx_if bif();

  console_uart_tx #(
    .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT), .CLKDIV(CLKDIV), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .resetn(resetn), .bus(bif), .irq_txe(irq_txe), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  // Line monitor: frame starts on the first low level, each bit sampled mid-cell.
  logic [8:0] rx_q[$];
  int         start_q[$];
  int         low_cnt = 0;
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh  = '0;
  logic       mon_err = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      mon_act = 1'b0;
    end else begin
      if (uart_tx !== 1'b1) low_cnt++;
      if (!mon_act && uart_tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        mon_err = 1'b0;
        start_q.push_back(cyc);
      end else if (mon_act) begin
        mon_cnt++;
      end
      if (mon_act && (mon_cnt % CLKDIV) == CLKDIV / 2) begin
        case (mon_cnt / CLKDIV)
          0: if (uart_tx !== 1'b0) mon_err = 1'b1;
          9: begin
            if (uart_tx !== 1'b1) mon_err = 1'b1;
            rx_q.push_back({mon_err, mon_sh});
          end
          default: mon_sh[mon_cnt / CLKDIV - 1] = uart_tx;
        endcase
      end
      if (mon_act && mon_cnt == FRAME - 1) mon_act = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    bif.mem_valid = 1'b1;
    bif.mem_addr  = a;
    bif.mem_wdata = d;
    bif.mem_wstrb = s;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bif.mem_ready !== 1'b1 && lat < 2000);
    rd = bif.mem_rdata;
    if (bif.mem_ready !== 1'b1) check("bus_ack_timeout", 64'(bif.mem_ready), 64'd1);
    bif.mem_valid = 1'b0;
    bif.mem_addr  = '0;
    bif.mem_wdata = '0;
    bif.mem_wstrb = '0;
  endtask

  task automatic wait_rx(input int base, input int n);
    int guard;
    guard = 0;
    while (rx_q.size() < base + n && guard < (n + 2) * FRAME + 100) begin
      step(1);
      guard++;
    end
    step(2 * CLKDIV);
    check("rx_count", 64'(rx_q.size() - base), 64'(n));
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / CLKDIV;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx - 1];
  endfunction

  initial begin
    logic [31:0] rd, d;
    logic [3:0]  s;
    logic [63:0] obs, expv;
    logic [31:0] fa [2];
    logic        any_rdy;
    logic [31:0] any_rd;
    int lat, t0, t, rxb, stb, lb, n, bad, gap;

    bif.mem_valid = 1'b0;
    bif.mem_addr  = '0;
    bif.mem_wdata = '0;
    bif.mem_wstrb = '0;

    // Reset
    resetn = 1'b0;
    step(5);
    check("rst_uart_tx", 64'(uart_tx), 64'd1);
    check("rst_irq", 64'(irq_txe), 64'd0);
    check("rst_ready", 64'(bif.mem_ready), 64'd0);
    check("rst_rdata", 64'(bif.mem_rdata), 64'd0);
    resetn = 1'b1;
    step(1);
    bus_xfer(A_STAT, 32'h0, 4'h0, rd, lat);
    check("rst_stat", 64'(rd), 64'h1);
    check("stat_lat", 64'(lat), 64'd1);
    bus_xfer(A_DATA, 32'hFFFF_FFFF, 4'h0, rd, lat);
    check("data_read", 64'(rd), 64'd0);
    step(1);
    check("idle_ready", 64'(bif.mem_ready), 64'd0);
    check("idle_rdata", 64'(bif.mem_rdata), 64'd0);

    // Single byte, exact waveform
    step(2);
    rxb = rx_q.size();
    bus_xfer(A_DATA, 32'hABCD_EF55, 4'h1, rd, lat);
    t0 = cyc;
    check("tx1_lat", 64'(lat), 64'd1);
    step(1);
    check("tx1_ready_drop", 64'(bif.mem_ready), 64'd0);
    check("tx1_pre", 64'(uart_tx), 64'd1);
    obs  = '0;
    expv = '0;
    for (int k = 0; k < FRAME; k++) begin
      step(1);
      obs[k]  = uart_tx;
      expv[k] = frame_bit(8'h55, k);
    end
    check("tx1_wave", obs, expv);
    step(1);
    check("tx1_idle", 64'(uart_tx), 64'd1);
    wait_rx(rxb, 1);
    check("tx1_byte", 64'(rx_q[rxb]), 64'h055);

    // Foreign addresses
    fa[0] = 32'h0001_0000;
    fa[1] = A_DATA + 32'h8;
    lb = low_cnt;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 2; w++) begin
        bif.mem_valid = 1'b1;
        bif.mem_addr  = fa[i];
        bif.mem_wdata = 32'h0000_005A;
        bif.mem_wstrb = (w == 1) ? 4'hF : 4'h0;
        any_rdy = 1'b0;
        any_rd  = '0;
        for (int c = 0; c < 6; c++) begin
          step(1);
          any_rdy = any_rdy | bif.mem_ready;
          any_rd  = any_rd | bif.mem_rdata;
        end
        check("foreign_ready", 64'(any_rdy), 64'd0);
        check("foreign_rdata", 64'(any_rd), 64'd0);
      end
    end
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = '0;
    step(1);
    bus_xfer(A_STAT, 32'h0, 4'h0, rd, lat);
    check("foreign_stat", 64'(rd), 64'h1);
    step(FRAME);
    check("foreign_no_tx", 64'(low_cnt - lb), 64'd0);

    // FIFO full: 18 back-to-back writes
    step(3);
    rxb = rx_q.size();
    stb = start_q.size();
    exp_q.delete();
    t0 = 0;
    for (int i = 0; i < 18; i++) begin
      d = $urandom;
      s = {3'($urandom_range(0, 7)), 1'b1};
      if (i == 17) begin
        bus_xfer(A_STAT, 32'h0, 4'h0, rd, lat);
        check("full_stat", 64'(rd), 64'(32'h0000_1006));
      end
      bus_xfer(A_DATA, d, s, rd, lat);
      exp_q.push_back(d[7:0]);
      if (i == 0) begin
        t0 = cyc;
        check("full_lat_first", 64'(lat), 64'd1);
      end else if (i <= 16) begin
        check("full_lat", 64'(lat), 64'd2);
      end else begin
        check("full_stall_release", 64'(cyc - t0), 64'(FRAME + 2));
      end
    end
    wait_rx(rxb, 18);
    for (int i = 0; i < 18; i++)
      check("full_byte", 64'(rx_q[rxb + i]), 64'({1'b0, exp_q[i]}));
    bad = 0;
    for (int i = 1; i < 18; i++)
      if (start_q[stb + i] - start_q[stb + i - 1] != FRAME) bad++;
    check("full_gapless", 64'(bad), 64'd0);

    // Interrupt
    check("irq_disabled", 64'(irq_txe), 64'd0);
    bus_xfer(A_STAT, 32'h8, 4'h1, rd, lat);
    step(1);
    check("irq_en_rise", 64'(irq_txe), 64'd1);
    bus_xfer(A_STAT, 32'h0, 4'h0, rd, lat);
    check("stat_irq_en", 64'(rd), 64'h9);
    rxb = rx_q.size();
    bus_xfer(A_DATA, 32'h3C, 4'h1, rd, lat);
    t = cyc;
    step(1);
    check("irq_fall_push", 64'(irq_txe), 64'd0);
    wait_until(t + FRAME / 2);
    check("irq_mid_frame", 64'(irq_txe), 64'd0);
    wait_until(t + FRAME + 1);
    check("irq_last_stop", 64'(irq_txe), 64'd0);
    step(1);
    check("irq_rise", 64'(irq_txe), 64'd1);
    bus_xfer(A_STAT, 32'h0, 4'h1, rd, lat);
    step(1);
    check("irq_clear", 64'(irq_txe), 64'd0);
    wait_rx(rxb, 1);
    check("irq_byte", 64'(rx_q[rxb]), 64'h03C);

    // Randomized bursts against the byte-queue model
    for (int r = 0; r < 4; r++) begin
      rxb = rx_q.size();
      exp_q.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        s = {3'($urandom_range(0, 7)), 1'b1};
        bus_xfer(A_DATA, d, s, rd, lat);
        exp_q.push_back(d[7:0]);
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FRAME) : 0;
        step(gap);
      end
      wait_rx(rxb, n);
      bad = 0;
      for (int i = 0; i < n; i++)
        if (rx_q[rxb + i] !== {1'b0, exp_q[i]}) bad++;
      check("rand_bytes", 64'(bad), 64'd0);
      bus_xfer(A_STAT, 32'h0, 4'h0, rd, lat);
      check("rand_stat_idle", 64'(rd), 64'h1);
    end

    // Reset mid-frame with 3 bytes queued behind the one being sent
    rxb = rx_q.size();
    bus_xfer(A_DATA, 32'h0, 4'h1, rd, lat);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      bus_xfer(A_DATA, d, 4'h1, rd, lat);
    end
    wait_until(t0 + CLKDIV + 6);
    check("rstmid_pre_low", 64'(uart_tx), 64'd0);
    resetn = 1'b0;
    step(1);
    check("rstmid_tx_high", 64'(uart_tx), 64'd1);
    step(2);
    resetn = 1'b1;
    lb = low_cnt;
    step(1);
    bus_xfer(A_STAT, 32'h0, 4'h0, rd, lat);
    check("rstmid_stat", 64'(rd), 64'h1);
    step(3 * FRAME);
    check("rstmid_quiet", 64'(low_cnt - lb), 64'd0);
    check("rstmid_no_rx", 64'(rx_q.size() - rxb), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
